// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID pipeline types: the fetch-to-decode flow record, the
// architectural NOP and the skid buffer occupancy states.
package if_id_skid_reg_pkg;

   // Word fetch presents to decode: pc in the upper half, instr in the lower.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_flow_t;

   // addi x0,x0,0 -- shown to decode whenever no valid entry is held.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Number of entries held: none, main only, main plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a 2-entry skid buffer. The main register
// drives decode directly. A second fetch word is parked in the skid
// register while decode stalls, so in_ready is registered and never
// depends combinationally on out_ready. Flush drops everything held or
// arriving. stall_cnt counts cycles in which decode applies back-pressure.
module if_id_skid_reg
   import if_id_skid_reg_pkg::if_id_flow_t,
          if_id_skid_reg_pkg::skid_state_e,
          if_id_skid_reg_pkg::EMPTY,
          if_id_skid_reg_pkg::ONE,
          if_id_skid_reg_pkg::TWO;
#(
   parameter logic [31:0] NOP_INSTR = if_id_skid_reg_pkg::NOP_INSTR,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_flow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_flow,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   skid_state_e      state_q, state_d;
   if_id_flow_t      main_q, main_d;
   if_id_flow_t      skid_q, skid_d;
   if_id_flow_t      in_flow_s;
   if_id_flow_t      idle_flow;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_xfer, out_xfer;

   assign in_flow_s = if_id_flow_t'(in_flow);
   assign idle_flow = '{pc: 32'h0, instr: NOP_INSTR};

   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid_q & out_ready;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_flow  = main_q;
   assign stall_cnt = cnt_q;

   // Occupancy FSM: choose what main/skid hold next; flush overrides all.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_d  = in_flow_s;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_flow_s;
            end else if (out_xfer) begin
               main_d  = idle_flow;
               state_d = EMPTY;
            end else if (in_xfer) begin
               skid_d  = in_flow_s;
               state_d = TWO;
            end
         end
         TWO: begin
            if (out_xfer) begin
               main_d  = skid_q;
               skid_d  = idle_flow;
               state_d = ONE;
            end
         end
         default: begin
            main_d  = idle_flow;
            skid_d  = idle_flow;
            state_d = EMPTY;
         end
      endcase

      if (flush) begin
         main_d  = idle_flow;
         skid_d  = idle_flow;
         state_d = EMPTY;
      end
   end

   // Handshake flags derive from the next occupancy, so both are pure flops.
   always_comb begin
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != TWO);
   end

   // Back-pressure counter: one per stalled cycle, frozen on flush, wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_q && !out_ready && !flush) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State, data and counter registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         main_q      <= '{pc: 32'h0, instr: NOP_INSTR};
         skid_q      <= '{pc: 32'h0, instr: NOP_INSTR};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Randomised and directed bench for if_id_skid_reg against a queue-based
// reference model. A second instance with a 4-bit counter exercises wrap.
module tb_if_id_skid_reg;

   localparam logic [63:0] IDLE = {32'h0, 32'h0000_0013};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_flow = '0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;

   logic        in_ready, out_valid;
   logic [63:0] out_flow;
   logic [31:0] stall_cnt;
   logic        in_ready4, out_valid4;
   logic [63:0] out_flow4;
   logic [3:0]  stall_cnt4;

   if_id_skid_reg dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_flow(in_flow), .out_valid(out_valid), .out_ready(out_ready),
      .out_flow(out_flow), .flush(flush), .stall_cnt(stall_cnt)
   );

   if_id_skid_reg #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .in_flow(in_flow), .out_valid(out_valid4), .out_ready(out_ready),
      .out_flow(out_flow4), .flush(flush), .stall_cnt(stall_cnt4)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   // Reference model: FIFO of held entries (capacity 2), registered ready, stall count.
   logic [63:0] mq[$];
   logic        m_rdy = 1'b1;
   int unsigned m_cnt = 0;

   // Output words seen by decode on each output transfer, taken from the DUT.
   logic [31:0] out_log[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_rdy = 1'b1;
      m_cnt = 0;
   endtask

   task automatic check_outputs();
      logic        ev;
      logic [63:0] ef;
      ev = (mq.size() != 0);
      ef = ev ? mq[0] : IDLE;
      chk("out_valid", {63'h0, out_valid}, {63'h0, ev});
      chk("out_flow", out_flow, ef);
      chk("in_ready", {63'h0, in_ready}, {63'h0, m_rdy});
      chk("stall_cnt", {32'h0, stall_cnt}, {32'h0, m_cnt});
      chk("out_valid4", {63'h0, out_valid4}, {63'h0, ev});
      chk("out_flow4", out_flow4, ef);
      chk("in_ready4", {63'h0, in_ready4}, {63'h0, m_rdy});
      chk("stall_cnt4", {60'h0, stall_cnt4}, {60'h0, m_cnt[3:0]});
   endtask

   // One clock: drive inputs at the falling edge, advance the model at the
   // rising edge, compare at the next falling edge.
   task automatic cycle(input logic iv, input logic [63:0] f, input logic ordy, input logic fl);
      logic in_x;
      in_valid  = iv;
      in_flow   = f;
      out_ready = ordy;
      flush     = fl;
      if (out_valid && out_ready) out_log.push_back(out_flow[63:32]);
      @(posedge clk);
      in_x = iv & m_rdy;
      if (fl) begin
         mq.delete();
         m_rdy = 1'b1;
      end else begin
         if (mq.size() != 0 && !ordy) m_cnt++;
         if (mq.size() != 0 && ordy) void'(mq.pop_front());
         if (in_x) mq.push_back(f);
         m_rdy = (mq.size() < 2);
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      flush = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      check_outputs();
   endtask

   function automatic logic [63:0] mk(input logic [31:0] pc);
      return {pc, 32'h0010_0093 ^ pc};
   endfunction

   initial begin
      logic [31:0] bp_pc[3];
      int unsigned idx;
      logic        acc;

      bp_pc[0] = 32'h10; bp_pc[1] = 32'h14; bp_pc[2] = 32'h18;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;

      // Streaming: pc 0,4,8,... with decode always ready.
      for (int i = 0; i < 8; i++) cycle(1'b1, mk(32'(i * 4)), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("stream_stall", {32'h0, stall_cnt}, 64'h0);

      // Back-pressure: fetch holds its word until accepted.
      out_log.delete();
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         acc = (idx < 3) && m_rdy;
         cycle(idx < 3, (idx < 3) ? mk(bp_pc[idx]) : 64'h0, c >= 4, 1'b0);
         if (acc) idx++;
         if (c == 1) chk("bp_skid_full", {63'h0, in_ready}, 64'h0);
      end
      chk("bp_order_n", {32'h0, 32'(out_log.size())}, 64'd3);
      if (out_log.size() == 3) begin
         chk("bp_order0", {32'h0, out_log[0]}, 64'h10);
         chk("bp_order1", {32'h0, out_log[1]}, 64'h14);
         chk("bp_order2", {32'h0, out_log[2]}, 64'h18);
      end

      // Flush while both entries are held, with a new word offered alongside.
      cycle(1'b1, mk(32'h30), 1'b0, 1'b0);
      cycle(1'b1, mk(32'h34), 1'b0, 1'b0);
      chk("two_ready", {63'h0, in_ready}, 64'h0);
      out_log.delete();
      cycle(1'b1, mk(32'h40), 1'b0, 1'b1);
      chk("flush_ov", {63'h0, out_valid}, 64'h0);
      chk("flush_nop", out_flow, IDLE);
      chk("flush_rdy", {63'h0, in_ready}, 64'h1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("flush_drop", {32'h0, 32'(out_log.size())}, 64'h0);

      // Flush from empty with a word offered.
      cycle(1'b1, mk(32'h50), 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("flush_empty", {63'h0, out_valid}, 64'h0);

      // Asynchronous reset in the middle of a cycle while one entry is held.
      cycle(1'b1, mk(32'h60), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1;
      model_reset();
      chk("areset_ov", {63'h0, out_valid}, 64'h0);
      chk("areset_flow", out_flow, IDLE);
      chk("areset_cnt", {32'h0, stall_cnt}, 64'h0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
      cycle(1'b1, mk(32'h70), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Counter wrap on the 4-bit instance: 17 stalled cycles.
      do_reset();
      cycle(1'b1, mk(32'h80), 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      chk("wrap4", {60'h0, stall_cnt4}, 64'h1);
      chk("wrap32", {32'h0, stall_cnt}, 64'd17);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
               $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
